// File: rtl/word_sum_pkg.sv
// Shared types and helpers for the word_sum scheduler: digit/sum widths, result state, ID width.
package word_sum_pkg;

   localparam int unsigned DIGIT_W = 2;
   localparam int unsigned SUM_W   = 10;
   localparam int unsigned MAX_N   = 99;

   typedef logic [SUM_W-1:0] sum_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } res_state_t;

   // Requester index width; a single requester still gets a 1-bit ID.
   function automatic int unsigned id_w(int unsigned n);
      return (n <= 1) ? 1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/word_sum_sched_if.sv
// Requester and result handshake bundle between the requesters/consumer and the scheduler.
interface word_sum_sched_if
   import word_sum_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned ID_W   = id_w(NUM_REQ);
   localparam int unsigned WORD_W = DIGIT_W * N;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*WORD_W-1:0] req_word;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      res_valid;
   logic                      res_ready;
   sum_t                      res_sum;
   logic [ID_W-1:0]           res_id;

   modport master (
      output req_valid, req_word, res_ready,
      input  req_ready, res_valid, res_sum, res_id
   );

   modport slave (
      input  req_valid, req_word, res_ready,
      output req_ready, res_valid, res_sum, res_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter
   import word_sum_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx
);

   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((32'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/word_sum.sv
// Combinational digit sum of an N-digit word of 2-bit digits.
module word_sum
   import word_sum_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [DIGIT_W*N-1:0] word,
   output sum_t                 sum
);

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = sum + SUM_W'(word[i*DIGIT_W +: DIGIT_W]);
      end
   end

endmodule

// File: rtl/word_sum_sched.sv
// Shares one word_sum datapath among NUM_REQ requesters via round-robin grant;
// results are registered with the requester ID behind a valid/ready port.
module word_sum_sched
   import word_sum_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   word_sum_sched_if.slave  bus,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int unsigned ID_W   = id_w(NUM_REQ);
   localparam int unsigned WORD_W = DIGIT_W * N;

   res_state_t           state;
   sum_t                 sum_q;
   logic [ID_W-1:0]      id_q;
   logic [ID_W-1:0]      ptr;
   logic [CNT_W-1:0]     cnt_q;

   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic [WORD_W-1:0]    sel_word;
   sum_t                 sel_sum;
   logic                 can_accept;
   logic                 accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_word = bus.req_word[32'(gnt_idx)*WORD_W +: WORD_W];

   word_sum #(.N(N)) u_sum (
      .word (sel_word),
      .sum  (sel_sum)
   );

   // Output register empty or draining this cycle frees the datapath.
   assign can_accept    = (state == EMPTY) || bus.res_ready;
   assign bus.req_ready = (rst_n && can_accept) ? gnt : '0;
   assign accept        = |bus.req_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         sum_q <= '0;
         id_q  <= '0;
         ptr   <= '0;
         cnt_q <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) state <= FULL;
            FULL:  if (bus.res_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         if (accept) begin
            sum_q <= sel_sum;
            id_q  <= gnt_idx;
            ptr   <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.res_valid = (state == FULL);
   assign bus.res_sum   = sum_q;
   assign bus.res_id    = id_q;
   assign word_cnt      = cnt_q;

endmodule
